// File: rtl/sample_rom_fetch_if.sv
// rtl/sample_rom_fetch_if.sv - MCU and SDRAM signal bundle for sample_rom_fetch
interface sample_rom_fetch_if;
  logic [1:0]  sample_addr_wr;
  logic [15:0] sample_addr;
  logic        sample_inc;
  logic [7:0]  sample_rom_data;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack;
  logic [15:0] sdr_data;
  logic        busy;

  modport master (
    output sample_addr_wr, sample_addr, sample_inc, sdr_ack, sdr_data,
    input  sample_rom_data, sdr_addr, sdr_req, busy
  );

  modport slave (
    input  sample_addr_wr, sample_addr, sample_inc, sdr_ack, sdr_data,
    output sample_rom_data, sdr_addr, sdr_req, busy
  );
endinterface

// File: rtl/sample_rom_fetch.sv
// rtl/sample_rom_fetch.sv - sample ROM byte fetch through a one-word SDRAM cache
// Optional next-word prefetch buffer: define SAMPLE_ROM_FETCH_PREFETCH_EN
module sample_rom_fetch #(
  parameter logic [24:0] SDR_BASE = 25'h0
) (
  input logic               CLK_32M,
  input logic               reset,
  sample_rom_fetch_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        valid_q;
  logic [14:0] tag_q, req_tag_q, fetch_tag;
  logic [15:0] word_q;
  logic [7:0]  data_q;
  logic [24:0] sdr_addr_q;
  logic        sdr_req_q = 1'b0;
  logic        addr_wr, hit, ack_match, avail, demand_fill;
  logic [15:0] avail_word;
  logic        cache_we;
  logic [15:0] cache_word;
  logic [14:0] cache_tag;

  assign addr_wr   = |bus.sample_addr_wr;
  assign hit       = valid_q && (tag_q == addr_q[15:1]);
  assign ack_match = (bus.sdr_ack == sdr_req_q);

  always_comb begin
    addr_d = addr_q;
    if (addr_wr) begin
      if (bus.sample_addr_wr[0]) addr_d[7:0]  = bus.sample_addr[7:0];
      if (bus.sample_addr_wr[1]) addr_d[15:8] = bus.sample_addr[15:8];
    end else if (bus.sample_inc) begin
      addr_d = addr_q + 16'd1;
    end
  end

`ifdef SAMPLE_ROM_FETCH_PREFETCH_EN
  logic        pf_valid_q, pf_kind_q, pf_kill_q;
  logic [14:0] pf_tag_q, next_tag;
  logic [15:0] pf_word_q;
  logic        pf_hit, pf_want, promote;

  assign next_tag    = tag_q + 15'd1;
  assign pf_hit      = pf_valid_q && (pf_tag_q == addr_q[15:1]);
  assign pf_want     = hit && !(pf_valid_q && (pf_tag_q == next_tag));
  assign promote     = (state_q == ST_IDLE) && !hit && pf_hit;
  assign avail       = hit || pf_hit;
  assign avail_word  = hit ? word_q : pf_word_q;
  assign fetch_tag   = pf_kind_q ? next_tag : addr_q[15:1];
  assign demand_fill = (state_q == ST_WAIT) && ack_match && !pf_kind_q;
`else
  assign avail       = hit;
  assign avail_word  = word_q;
  assign fetch_tag   = addr_q[15:1];
  assign demand_fill = (state_q == ST_WAIT) && ack_match;
`endif

  always_comb begin
    cache_we   = demand_fill;
    cache_word = bus.sdr_data;
    cache_tag  = req_tag_q;
`ifdef SAMPLE_ROM_FETCH_PREFETCH_EN
    if (promote) begin
      cache_we   = 1'b1;
      cache_word = pf_word_q;
      cache_tag  = pf_tag_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef SAMPLE_ROM_FETCH_PREFETCH_EN
        if ((!hit && !pf_hit) || pf_want) state_d = ST_REQ;
`else
        if (!hit) state_d = ST_REQ;
`endif
      end
      ST_REQ:            state_d = ST_WAIT;
      ST_WAIT, ST_DRAIN: if (ack_match) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // A request left in flight by reset must be drained before a new toggle.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q    <= ack_match ? ST_IDLE : ST_DRAIN;
      addr_q     <= 16'h0000;
      valid_q    <= 1'b0;
      tag_q      <= 15'h0000;
      word_q     <= 16'h0000;
      req_tag_q  <= 15'h0000;
      data_q     <= 8'h00;
      sdr_addr_q <= SDR_BASE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (avail) data_q <= addr_q[0] ? avail_word[15:8] : avail_word[7:0];
      if (state_q == ST_REQ) begin
        sdr_addr_q <= SDR_BASE + {9'd0, fetch_tag, 1'b0};
        req_tag_q  <= fetch_tag;
      end
      if (cache_we) begin
        word_q  <= cache_word;
        tag_q   <= cache_tag;
        valid_q <= 1'b1;
      end
      if (demand_fill && (req_tag_q == addr_q[15:1]))
        data_q <= addr_q[0] ? bus.sdr_data[15:8] : bus.sdr_data[7:0];
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (!reset && (state_q == ST_REQ)) sdr_req_q <= ~sdr_req_q;
  end

`ifdef SAMPLE_ROM_FETCH_PREFETCH_EN
  // An address write while a prefetch is in flight kills that fill.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      pf_valid_q <= 1'b0;
      pf_kind_q  <= 1'b0;
      pf_kill_q  <= 1'b0;
      pf_tag_q   <= 15'h0000;
      pf_word_q  <= 16'h0000;
    end else begin
      if ((state_q == ST_IDLE) && (state_d == ST_REQ)) pf_kind_q <= hit;
      if (state_q == ST_REQ) pf_kill_q <= 1'b0;
      if ((state_q == ST_WAIT) && ack_match && pf_kind_q && !pf_kill_q && !addr_wr) begin
        pf_word_q  <= bus.sdr_data;
        pf_tag_q   <= req_tag_q;
        pf_valid_q <= 1'b1;
      end
      if (promote) pf_valid_q <= 1'b0;
      if (addr_wr) begin
        pf_valid_q <= 1'b0;
        pf_kill_q  <= 1'b1;
      end
    end
  end
`endif

  assign bus.sample_rom_data = data_q;
  assign bus.sdr_addr        = sdr_addr_q;
  assign bus.sdr_req         = sdr_req_q;
  assign bus.busy            = (state_q == ST_DRAIN) || !avail;
endmodule

// File: doc/sample_rom_fetch.md
SAMPLE_ROM_FETCH -- requirements
Module: sample_rom_fetch

Interface
REQ-001 SDR_BASE, 25'h0, byte base address of the 64 KB sample region in SDRAM.
REQ-002 CLK_32M  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 sample_addr_wr  in  2  bit0 loads address[7:0], bit1 loads address[15:8]; one-cycle pulses from the sample MCU.
REQ-005 sample_addr  in  16  address byte source; [7:0] for bit0, [15:8] for bit1.
REQ-006 sample_inc  in  1  one-cycle pulse, post-increment the address.
REQ-007 sample_rom_data  out  8  byte at the current address, fed to the MCU read mux.
REQ-008 sdr_addr  out  25  SDRAM byte address, word-aligned (bit0 = 0).
REQ-009 sdr_req  out  1  toggle request; a new request is issued by inverting it.
REQ-010 sdr_ack  in  1  toggle acknowledge; a request is complete when sdr_ack == sdr_req.
REQ-011 sdr_data  in  16  SDRAM word, valid in the cycle the acknowledge matches.
REQ-012 busy  out  1  high while the current-address word is not yet held.

Function
REQ-013 Address register: 16 bit; sample_addr_wr bits act independently, and both bits in one cycle load all 16 bits.
REQ-014 sample_inc: address increments by 1; FFFF wraps to 0000; no carry to any other state.
REQ-015 sample_inc and sample_addr_wr in the same cycle: write wins; the increment is dropped.
REQ-016 Cache: one 16-bit word with a 15-bit tag (address[15:1]) and a valid bit.
REQ-017 Hit (valid and tag == address[15:1]): sample_rom_data = address[0] ? word[15:8] : word[7:0], registered, 1-cycle latency after the address change.
REQ-018 Miss: sample_rom_data holds its previous value and busy = 1.
REQ-019 FSM states: IDLE, REQ, WAIT, DRAIN.
REQ-020 IDLE -> REQ on miss.
REQ-021 REQ (1 cycle): sdr_addr = SDR_BASE + {address[15:1],1'b0}; toggle sdr_req; record the requested tag; go to WAIT.
REQ-022 WAIT -> IDLE when sdr_ack == sdr_req; the word and the recorded tag are written to the cache and valid is set.
REQ-023 Address change during WAIT: the request completes and fills normally; the resulting tag mismatch causes a refetch from IDLE.
REQ-024 At most one request is outstanding at any time; sdr_req does not toggle again until the acknowledge matches.
REQ-025 sdr_addr holds stable from REQ until the acknowledge matches.
REQ-026 The byte is sampled with address[0] at fill time; an odd/even change within the same word needs no fetch.

Reset
REQ-027 On reset: address = 0, valid = 0, prefetch valid = 0, sample_rom_data = 8'h00, sdr_addr = SDR_BASE.
REQ-028 sdr_req is never reset; its power-up value is 0.
REQ-029 Reset with sdr_ack == sdr_req: the FSM enters IDLE and fetches word 0 on the next cycle.
REQ-030 Reset with sdr_ack != sdr_req: the FSM enters DRAIN, discards the data when the acknowledge matches, then goes to IDLE.
REQ-031 busy = 1 throughout DRAIN.

Configuration
REQ-032 Macro SAMPLE_ROM_FETCH_PREFETCH_EN selects the prefetch buffer.
REQ-033 With SAMPLE_ROM_FETCH_PREFETCH_EN: a second word buffer with tag and valid bit is added.
REQ-034 Prefetch issue: after each demand fill, when IDLE and the cache hits, the word at tag+1 (wrapping 7FFF -> 0000) is requested into the prefetch buffer.
REQ-035 Prefetch promote: when the address moves to the prefetch tag, the prefetch word moves to the cache in 1 cycle with no SDRAM access, and the next prefetch issues.
REQ-036 Address write: the prefetch buffer is invalidated.
REQ-037 Demand miss while a prefetch is in flight: the prefetch completes first, then the demand fetch issues.
REQ-038 Without SAMPLE_ROM_FETCH_PREFETCH_EN: demand fetch only; no second buffer exists.

Verification
REQ-039 Reset; SDRAM model acks after 6 cycles with word 16'hA55A at SDR_BASE -> one request at SDR_BASE, busy falls, sample_rom_data = 8'h5A; then sample_inc -> 8'hA5 next cycle, no new request.
REQ-040 Write 8'h34 on bit0, then 8'h12 on bit1 -> request at SDR_BASE + 16'h1234, sample_rom_data = low byte of word 0x091A.
REQ-041 Address FFFF, then sample_inc -> address 0000, request at SDR_BASE, busy asserted until the acknowledge.
REQ-042 sample_addr_wr = 2'b11 with sample_addr 16'h0100 and sample_inc in the same cycle -> address 0100, not 0101.
REQ-043 Address write to 0x2000 during WAIT for 0x1000 -> the 0x1000 fill completes, then exactly one request for 0x2000; sdr_req toggles twice in total.
REQ-044 Reset asserted during WAIT with the ack delayed 10 cycles -> DRAIN, no sdr_req toggle until the acknowledge matches, then a fresh request for word 0; with the macro enabled, inc across a word boundary -> no stall, busy stays 0.
